// File: rtl/ctrl_defs.sv
// Shared definitions for the multicycle MIPS control unit:
// opcodes, state encodings, datapath select codes, decode dispatch.
package ctrl_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] WR_RT   = 2'b00;
    localparam logic [1:0] WR_RD   = 2'b01;
    localparam logic [1:0] WR_SRC3 = 2'b10;
    localparam logic [1:0] WR_RA   = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_MEM    = 2'b11;

    localparam logic [1:0] IORD_PC     = 2'b00;
    localparam logic [1:0] IORD_ALUOUT = 2'b01;
    localparam logic [1:0] IORD_OVF    = 2'b10;
    localparam logic [1:0] IORD_OPC    = 2'b11;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [2:0] ALU_NONE  = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_FUNCT = 3'b100;

    typedef enum logic [4:0] {
        ST_RESET        = 5'd0,
        ST_FETCH        = 5'd1,
        ST_FETCH_WAIT   = 5'd2,
        ST_DECODE       = 5'd3,
        ST_EXEC_R       = 5'd4,
        ST_WB_R         = 5'd5,
        ST_EXEC_I       = 5'd6,
        ST_WB_I         = 5'd7,
        ST_ADDR         = 5'd8,
        ST_MEM_RD       = 5'd9,
        ST_LW_WB        = 5'd10,
        ST_MEM_WR       = 5'd11,
        ST_BEQ          = 5'd12,
        ST_BNE          = 5'd13,
        ST_JUMP         = 5'd14,
        ST_JAL          = 5'd15,
        ST_JR           = 5'd16,
        ST_EXC_OVF      = 5'd17,
        ST_EXC_OPC      = 5'd18,
        ST_EXC_WAIT_OVF = 5'd19,
        ST_EXC_WAIT_OPC = 5'd20
    } state_t;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       br_ne;
        logic [1:0] pc_src;
        logic [1:0] iord;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] wr_reg_sel;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ab_wr;
        logic       aluout_wr;
        logic       mdr_wr;
        logic       epc_wr;
    } ctrl_t;

    function automatic state_t dispatch(input logic [5:0] op,
                                        input logic [5:0] fn);
        state_t s;
        s = ST_EXC_OPC;
        case (op)
            OP_RTYPE: s = (fn == FN_JR) ? ST_JR : ST_EXEC_R;
            OP_ADDI:  s = ST_EXEC_I;
            OP_LW,
            OP_SW:    s = ST_ADDR;
            OP_BEQ:   s = ST_BEQ;
            OP_BNE:   s = ST_BNE;
            OP_J:     s = ST_JUMP;
            OP_JAL:   s = ST_JAL;
            default:  s = ST_EXC_OPC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Loadable 3-bit down-counter for memory wait states.
// done is high whenever the count has reached zero.
module ctrl_wait_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       done
);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign done = (cnt == 3'd0);

endmodule

// File: rtl/ctrl_unit_fsm.sv
// Multicycle MIPS control unit: Moore FSM driving all datapath
// selects and write enables, with memory waits and exceptions.
module ctrl_unit_fsm
    import ctrl_defs::*;
#(
    parameter int          MEM_WAIT    = 2,
    parameter logic [31:0] EXC_VEC_OVF = 32'd254,
    parameter logic [31:0] EXC_VEC_OPC = 32'd253
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic       br_ne,
    output logic [1:0] pc_src,
    output logic [1:0] iord,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] wr_reg_sel,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       ab_wr,
    output logic       aluout_wr,
    output logic       mdr_wr,
    output logic       epc_wr,
    output logic [4:0] state_dbg
);

    if (MEM_WAIT < 1 || MEM_WAIT > 7 || EXC_VEC_OVF == EXC_VEC_OPC) begin : g_bad_param
        $error("ctrl_unit_fsm: invalid parameters");
    end

    localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT - 1);

    state_t state, state_nx;
    ctrl_t  c;
    logic   wait_ld, wait_done;

    // Branch resolution on the zero flag happens in the PC write gate.
    logic unused_in;
    assign unused_in = alu_zero;

    ctrl_wait_cnt u_wait (
        .clk      (clk),
        .rst_n    (reset),
        .load     (wait_ld),
        .load_val (WAIT_LD),
        .done     (wait_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RESET;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = ST_RESET;
        c        = '0;
        wait_ld  = 1'b0;
        case (state)
            ST_RESET: state_nx = ST_FETCH;
            ST_FETCH, ST_FETCH_WAIT: begin
                c.iord      = IORD_PC;
                c.alu_src_b = SRCB_4;
                c.alu_op    = ALU_ADD;
                wait_ld     = (state == ST_FETCH);
                state_nx    = ST_FETCH_WAIT;
                if (state == ST_FETCH_WAIT && wait_done) begin
                    c.ir_wr  = 1'b1;
                    c.pc_wr  = 1'b1;
                    c.pc_src = PCS_ALU;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                c.ab_wr     = 1'b1;
                c.aluout_wr = 1'b1;
                c.alu_src_b = SRCB_BR;
                c.alu_op    = ALU_ADD;
                state_nx    = dispatch(opcode, funct);
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_FUNCT;
                c.aluout_wr = 1'b1;
                state_nx    = alu_ovf ? ST_EXC_OVF : ST_WB_R;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.aluout_wr = 1'b1;
                state_nx    = alu_ovf ? ST_EXC_OVF : ST_WB_I;
            end
            ST_WB_R, ST_WB_I: begin
                c.reg_wr     = 1'b1;
                c.wr_reg_sel = (state == ST_WB_R) ? WR_RD : WR_RT;
                c.mem_to_reg = M2R_ALUOUT;
                state_nx     = ST_FETCH;
            end
            ST_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.aluout_wr = 1'b1;
                wait_ld     = 1'b1;
                state_nx    = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                c.iord   = IORD_ALUOUT;
                c.mdr_wr = wait_done;
                state_nx = wait_done ? ST_LW_WB : ST_MEM_RD;
            end
            ST_LW_WB: begin
                c.reg_wr     = 1'b1;
                c.wr_reg_sel = WR_RT;
                c.mem_to_reg = M2R_MDR;
                state_nx     = ST_FETCH;
            end
            ST_MEM_WR: begin
                c.iord   = IORD_ALUOUT;
                c.mem_wr = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_BEQ, ST_BNE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_B;
                c.alu_op     = ALU_SUB;
                c.pc_wr_cond = 1'b1;
                c.pc_src     = PCS_ALUOUT;
                c.br_ne      = (state == ST_BNE);
                state_nx     = ST_FETCH;
            end
            ST_JUMP: begin
                c.pc_wr  = 1'b1;
                c.pc_src = PCS_JUMP;
                state_nx = ST_FETCH;
            end
            ST_JAL: begin
                c.reg_wr     = 1'b1;
                c.wr_reg_sel = WR_RA;
                c.mem_to_reg = M2R_PC;
                c.pc_wr      = 1'b1;
                c.pc_src     = PCS_JUMP;
                state_nx     = ST_FETCH;
            end
            ST_JR: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_NONE;
                c.pc_wr     = 1'b1;
                c.pc_src    = PCS_ALU;
                state_nx    = ST_FETCH;
            end
            // EPC captures PC-4 while the handler vector is being read.
            ST_EXC_OVF, ST_EXC_OPC: begin
                c.epc_wr    = 1'b1;
                c.alu_src_b = SRCB_4;
                c.alu_op    = ALU_SUB;
                c.iord      = (state == ST_EXC_OVF) ? IORD_OVF : IORD_OPC;
                wait_ld     = 1'b1;
                state_nx    = (state == ST_EXC_OVF) ? ST_EXC_WAIT_OVF
                                                    : ST_EXC_WAIT_OPC;
            end
            ST_EXC_WAIT_OVF, ST_EXC_WAIT_OPC: begin
                c.iord   = (state == ST_EXC_WAIT_OVF) ? IORD_OVF : IORD_OPC;
                state_nx = state;
                if (wait_done) begin
                    c.pc_wr  = 1'b1;
                    c.pc_src = PCS_MEM;
                    state_nx = ST_FETCH;
                end
            end
            default: state_nx = ST_RESET;
        endcase
    end

    assign pc_wr      = c.pc_wr;
    assign pc_wr_cond = c.pc_wr_cond;
    assign br_ne      = c.br_ne;
    assign pc_src     = c.pc_src;
    assign iord       = c.iord;
    assign mem_wr     = c.mem_wr;
    assign ir_wr      = c.ir_wr;
    assign reg_wr     = c.reg_wr;
    assign wr_reg_sel = c.wr_reg_sel;
    assign mem_to_reg = c.mem_to_reg;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign alu_op     = c.alu_op;
    assign ab_wr      = c.ab_wr;
    assign aluout_wr  = c.aluout_wr;
    assign mdr_wr     = c.mdr_wr;
    assign epc_wr     = c.epc_wr;
    assign state_dbg  = state;

endmodule
